// File: rtl/df_pkg.sv
// Shared definitions for the filter display path: the segment font, the
// converter state codes and the digit count.
package df_pkg;

    localparam int NDIG = 3;

    // Segment patterns, bit 0 = a .. bit 6 = g, active-high
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b1111100;
    localparam logic [6:0] SEG_C     = 7'b0111001;
    localparam logic [6:0] SEG_D     = 7'b1011110;
    localparam logic [6:0] SEG_E     = 7'b1111001;
    localparam logic [6:0] SEG_F     = 7'b1110001;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Converter FSM state codes
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    // Map one nibble to its hex-font segment pattern
    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'h0:    glyph = SEG_0;
            4'h1:    glyph = SEG_1;
            4'h2:    glyph = SEG_2;
            4'h3:    glyph = SEG_3;
            4'h4:    glyph = SEG_4;
            4'h5:    glyph = SEG_5;
            4'h6:    glyph = SEG_6;
            4'h7:    glyph = SEG_7;
            4'h8:    glyph = SEG_8;
            4'h9:    glyph = SEG_9;
            4'hA:    glyph = SEG_A;
            4'hB:    glyph = SEG_B;
            4'hC:    glyph = SEG_C;
            4'hD:    glyph = SEG_D;
            4'hE:    glyph = SEG_E;
            default: glyph = SEG_F;
        endcase
    endfunction

endpackage

// File: rtl/df_bin2bcd_seq.sv
// Sequential double-dabble: converts an 8-bit value to three BCD digits
// over eight shift cycles, then flags done for one cycle.
module df_bin2bcd_seq
    import df_pkg::*;
(
    input  logic       CLK,
    input  logic       nRST,
    input  logic       start,
    input  logic [7:0] bin,
    output logic       done,
    output logic [9:0] bcd,
    output logic       busy
);

    logic [1:0] state;
    logic [2:0] step_cnt;
    logic [7:0] bin_q;
    logic [9:0] bcd_q;
    logic [8:0] bcd_adj;

    // Add-3 correction on tens and units; hundreds never exceeds 2 so it needs none
    always_comb begin
        bcd_adj[8] = bcd_q[8];
        bcd_adj[7:4] = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
        bcd_adj[3:0] = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
    end

    // Conversion FSM: load on start, eight adjust-and-shift steps, one commit cycle
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= ST_IDLE;
            step_cnt <= 3'd0;
            bin_q    <= 8'd0;
            bcd_q    <= 10'd0;
            busy     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        bin_q    <= bin;
                        bcd_q    <= 10'd0;
                        step_cnt <= 3'd0;
                        busy     <= 1'b1;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    bcd_q    <= {bcd_adj, bin_q[7]};
                    bin_q    <= {bin_q[6:0], 1'b0};
                    step_cnt <= step_cnt + 3'd1;
                    if (step_cnt == 3'd7) begin
                        state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign done = (state == ST_COMMIT);
    assign bcd  = bcd_q;

endmodule

// File: rtl/df_seg7_display.sv
// Three-digit multiplexed 7-segment display for the filtered sample:
// periodic capture, decimal/hex conversion, scanning with ghost blanking
// and leading-zero suppression.
module df_seg7_display
    import df_pkg::*;
#(
    parameter int REFRESH_DIV = 1024,
    parameter int SAMPLE_DIV  = 65536,
    parameter bit LZ_BLANK    = 1'b1
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic [7:0] datain,
    input  logic       hexmode,
    output logic [6:0] seg,
    output logic       dp,
    output logic [2:0] digit_en,
    output logic       busy
);

    localparam int SW = $clog2(SAMPLE_DIV);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam logic [SW-1:0] SAMPLE_LAST  = SW'(SAMPLE_DIV - 1);
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);

    logic [SW-1:0] sample_cnt;
    logic          tick;
    logic          start;
    logic          conv_done;
    logic          conv_busy;
    logic [9:0]    conv_bcd;
    logic [7:0]    data_q;
    logic          hex_q;

    logic [3:0]    dig0_q, dig1_q, dig2_q;
    logic [3:0]    dig0_nxt, dig1_nxt, dig2_nxt;
    logic          hex_disp_q, hex_disp_nxt;
    logic          valid_q, valid_nxt;

    logic [RW-1:0] scan_cnt, scan_nxt;
    logic [1:0]    slot, slot_nxt;
    logic [3:0]    cur_digit;
    logic          cur_blank;
    logic          dark;
    logic [6:0]    seg_d;
    logic [2:0]    en_d;
    logic          dp_d;

    assign tick  = (sample_cnt == SAMPLE_LAST);
    assign start = tick && !conv_busy;

    // Free-running sample period counter; its wrap is the capture tick
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sample_cnt <= '0;
        end else if (tick) begin
            sample_cnt <= '0;
        end else begin
            sample_cnt <= sample_cnt + SW'(1);
        end
    end

    // Hold the captured sample and mode for the whole conversion
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            data_q <= 8'd0;
            hex_q  <= 1'b0;
        end else if (start) begin
            data_q <= datain;
            hex_q  <= hexmode;
        end
    end

    df_bin2bcd_seq u_conv (
        .CLK  (CLK),
        .nRST (nRST),
        .start(start),
        .bin  (datain),
        .done (conv_done),
        .bcd  (conv_bcd),
        .busy (conv_busy)
    );

    assign busy = conv_busy;

    // Next display contents: all three digits change together on commit
    always_comb begin
        dig0_nxt     = dig0_q;
        dig1_nxt     = dig1_q;
        dig2_nxt     = dig2_q;
        hex_disp_nxt = hex_disp_q;
        valid_nxt    = valid_q;
        if (conv_done) begin
            valid_nxt    = 1'b1;
            hex_disp_nxt = hex_q;
            if (hex_q) begin
                dig0_nxt = data_q[3:0];
                dig1_nxt = data_q[7:4];
                dig2_nxt = 4'd0;
            end else begin
                dig0_nxt = conv_bcd[3:0];
                dig1_nxt = conv_bcd[7:4];
                dig2_nxt = {2'b00, conv_bcd[9:8]};
            end
        end
    end

    // Display digit registers; dark until the first commit after reset
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            dig0_q     <= 4'd0;
            dig1_q     <= 4'd0;
            dig2_q     <= 4'd0;
            hex_disp_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            dig0_q     <= dig0_nxt;
            dig1_q     <= dig1_nxt;
            dig2_q     <= dig2_nxt;
            hex_disp_q <= hex_disp_nxt;
            valid_q    <= valid_nxt;
        end
    end

    // Scan position for the next cycle, so the registered outputs line up with it
    always_comb begin
        scan_nxt = scan_cnt + RW'(1);
        slot_nxt = slot;
        if (scan_cnt == REFRESH_LAST) begin
            scan_nxt = '0;
            slot_nxt = (slot == 2'd2) ? 2'd0 : slot + 2'd1;
        end
    end

    // Scan counter and slot index
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            scan_cnt <= '0;
            slot     <= 2'd0;
        end else begin
            scan_cnt <= scan_nxt;
            slot     <= slot_nxt;
        end
    end

    // Select the digit for the slot and decide whether it is blanked
    always_comb begin
        case (slot_nxt)
            2'd0: begin
                cur_digit = dig0_nxt;
                cur_blank = 1'b0;
            end
            2'd1: begin
                cur_digit = dig1_nxt;
                cur_blank = !hex_disp_nxt && LZ_BLANK && (dig2_nxt == 4'd0) && (dig1_nxt == 4'd0);
            end
            default: begin
                cur_digit = dig2_nxt;
                cur_blank = hex_disp_nxt || (LZ_BLANK && (dig2_nxt == 4'd0));
            end
        endcase
        dark  = !valid_nxt || (scan_nxt == '0);
        seg_d = (dark || cur_blank) ? SEG_BLANK : glyph(cur_digit);
        en_d  = dark ? 3'b000 : (3'b001 << slot_nxt);
        dp_d  = !dark && hex_disp_nxt && (slot_nxt == 2'd0);
    end

    // Registered pad outputs
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            seg      <= 7'd0;
            dp       <= 1'b0;
            digit_en <= 3'd0;
        end else begin
            seg      <= seg_d;
            dp       <= dp_d;
            digit_en <= en_d;
        end
    end

endmodule
